pc_unit: RTL
============

Name: pc_unit

Overview:
Parametrised program-counter generator feeding the fetch stage.
- Holds the current fetch PC and advances it by a configurable step.
- Accepts jump (ID), branch (EX) and trap (CSR) redirects with fixed priority.
- Supports fetch backpressure and pipeline stall, and emits a flush pulse to younger stages on any redirect.

Parameters:
PC_WIDTH, `PC_WIDTH (from defines_bitwidth.vh), PC register width
PC_STEP, 1, increment per sequential fetch
RESET_VEC, 0, PC value loaded on reset
RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN; power of two, >=2)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard stall from decode; hold PC
fetch_ready  in  1  fetch accepts current pc
trap_req  in  1  trap/interrupt redirect request
trap_vec  in  PC_WIDTH  trap target
br_taken  in  1  EX-stage branch resolved taken
br_target  in  PC_WIDTH  branch target
jmp_req  in  1  ID-stage unconditional jump
jmp_target  in  PC_WIDTH  jump target
call_req  in  1  ID jump is a call (RAS push; ignored without PC_RAS_EN)
ret_req  in  1  ID return (RAS pop; ignored without PC_RAS_EN)
pc  out  PC_WIDTH  current fetch address
pc_valid  out  1  pc is a valid fetch request
flush  out  1  one-cycle pulse: kill younger in-flight instructions

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_VEC, pc_valid=0, flush=0. RAS pointer and count are cleared.
- First edge with rst=0: pc_valid becomes 1 and pc stays RESET_VEC. pc_valid then stays 1 until the next reset.
- Next-PC priority, evaluated each edge with rst=0, highest first:
  1. trap_req -> trap_vec
  2. br_taken -> br_target
  3. jmp_req -> jmp_target (or RAS top if ret_req with PC_RAS_EN)
  4. stall, or !fetch_ready -> hold pc
  5. pc_valid && fetch_ready -> pc + PC_STEP
- Redirects (1-3) ignore stall and fetch_ready. They take effect at the next edge, so latency is 1 cycle.
- flush is registered. It equals 1 in the cycle the redirected pc appears and 0 otherwise. Simultaneous redirects produce a single flush pulse, and the winner is chosen by priority.
- Arithmetic: pc + PC_STEP wraps modulo 2^PC_WIDTH with no overflow flag. Targets are taken verbatim, with no alignment check.
- Redirects arriving while pc_valid=0 (the first post-reset cycle) are honoured. pc_valid still rises the same edge.
- rst asserted mid-stall or mid-redirect overrides everything at that edge.

Optional Feature:
PC_RAS_EN
- Defined:
  - A RAS_DEPTH-entry circular return-address stack is built in.
  - Call: jmp_req && call_req, not overridden by br_taken or trap_req. Push pc+PC_STEP.
  - Return: jmp_req && ret_req with a non-empty stack. Next pc = top, then pop.
  - Return with an empty stack uses jmp_target.
  - A push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - call_req && ret_req together: pop then push (top replaced).
  - trap_req and br_taken do not modify the RAS.
- Undefined: call_req and ret_req are unused, and jumps always use jmp_target.

Decomposition:
- defines_bitwidth.vh keeps `PC_WIDTH. Add a pc_unit_defs.vh with redirect-source encodings (TRAP/BR/JMP/SEQ/HOLD) used for debug and assertions.
- One natural sub-module: pc_ras (circular stack, push/pop/top/empty), instantiated only under PC_RAS_EN.

Test Plan:
- Reset then free-run, PC_WIDTH=8, PC_STEP=1, RESET_VEC=8'hF0:
  - pc F0 is held one cycle with pc_valid 0→1.
  - pc then runs F1..FF, 00, wrapping with no glitch.
- Backpressure: fetch_ready=0 for 3 cycles at pc=05, then stall=1 for 2 cycles → pc holds 05 for 5 cycles, then 06, with flush=0 throughout.
- Priority: trap_req, br_taken and jmp_req all set with targets 80, 40, 20 → next pc=80, flush=1 for exactly one cycle. Dropping trap_req alone → pc=40.
- Redirect during stall: stall=1, br_taken with br_target=33 → pc=33 next cycle, flush=1. Then pc holds 33 while stall stays 1.
- Reset mid-redirect: rst=1 with jmp_req and jmp_target=55 → pc=RESET_VEC, pc_valid=0, flush=0.
- PC_RAS_EN, RAS_DEPTH=2:
  - Call at pc=10 then call at pc=20 → the stack holds 11 and 21. A third call at pc=30 overwrites 11.
  - ret ×2 → pc=31, then 21. A third ret with jmp_target=77 → pc=77.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared types for the program-counter unit: redirect-source encodings
// and next-PC source selection. Default `PC_WIDTH is 32 when not supplied.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package pc_unit_pkg;

    typedef enum logic [2:0] {
        SRC_HOLD = 3'd0,
        SRC_SEQ  = 3'd1,
        SRC_JMP  = 3'd2,
        SRC_BR   = 3'd3,
        SRC_TRAP = 3'd4
    } pc_src_e;

    // Fixed priority: trap > branch > jump > hold > sequential
    function automatic pc_src_e pick_src(
        input logic trap,
        input logic br,
        input logic jmp,
        input logic stall,
        input logic ready,
        input logic valid
    );
        if (trap)
            return SRC_TRAP;
        else if (br)
            return SRC_BR;
        else if (jmp)
            return SRC_JMP;
        else if (stall || !ready || !valid)
            return SRC_HOLD;
        else
            return SRC_SEQ;
    endfunction

    function automatic logic is_redirect(input pc_src_e src);
        return (src == SRC_TRAP) || (src == SRC_BR) || (src == SRC_JMP);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest
// entry, and push+pop together replaces the top.
module pc_ras
    import pc_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] waddr;
    logic             we;
    logic             pop_ok;

    assign empty  = (cnt_q == '0);
    assign pop_ok = pop && !empty;
    assign top    = mem_q[ptr_q - PTR_W'(1)];

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        we    = 1'b0;
        waddr = ptr_q;
        if (push && pop_ok) begin
            we    = 1'b1;
            waddr = ptr_q - PTR_W'(1);
        end else if (push) begin
            we    = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH))
                cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_ok) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entries need no reset: they are unreadable until pushed
    always_ff @(posedge clk) begin
        if (we && !rst)
            mem_q[waddr] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program-counter generator with trap/branch/jump redirects and
// registered flush. Optional return-address stack under PC_RAS_EN.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                  PC_WIDTH  = `PC_WIDTH,
    parameter int                  PC_STEP   = 1,
    parameter logic [PC_WIDTH-1:0] RESET_VEC = '0,
    parameter int                  RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                fetch_ready,
    input  logic                trap_req,
    input  logic [PC_WIDTH-1:0] trap_vec,
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                jmp_req,
    input  logic [PC_WIDTH-1:0] jmp_target,
    input  logic                call_req,
    input  logic                ret_req,
    output logic [PC_WIDTH-1:0] pc,
    output logic                pc_valid,
    output logic                flush
);

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RAS_DEPTH must be a power of two >= 2");
    end

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                valid_q;
    logic                flush_q, flush_d;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] jmp_dst;
    pc_src_e             src;

    assign seq_pc = pc_q + STEP;
    assign src    = pick_src(trap_req, br_taken, jmp_req,
                             stall, fetch_ready, valid_q);

`ifdef PC_RAS_EN
    logic                jmp_wins;
    logic [PC_WIDTH-1:0] ras_top;
    logic                ras_empty;

    assign jmp_wins = jmp_req && !br_taken && !trap_req;

    pc_ras #(
        .DEPTH(RAS_DEPTH),
        .W    (PC_WIDTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (jmp_wins && call_req),
        .pop      (jmp_wins && ret_req),
        .push_data(seq_pc),
        .top      (ras_top),
        .empty    (ras_empty)
    );

    assign jmp_dst = (ret_req && !ras_empty) ? ras_top : jmp_target;
`else
    logic unused_ras_reqs;
    assign unused_ras_reqs = call_req ^ ret_req;
    assign jmp_dst         = jmp_target;
`endif

    always_comb begin
        pc_d    = pc_q;
        flush_d = is_redirect(src);
        unique case (src)
            SRC_TRAP: pc_d = trap_vec;
            SRC_BR:   pc_d = br_target;
            SRC_JMP:  pc_d = jmp_dst;
            SRC_SEQ:  pc_d = seq_pc;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            flush_q <= flush_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = valid_q;
    assign flush    = flush_q;

endmodule
